entry_parking_lot: RTL and testbench
====================================

// Module: entry_parking_lot
// PURPOSE
//   Entry-side slot allocator for the parking lot.
//   - Tracks an occupancy map of all slots.
//   - On a car-arrival request, grants the lowest-numbered free slot as park_number.
//   - Accepts exit notifications by slot number and frees that slot.
//   - Complements the exit path, which maps park_number to a one-hot park_location.
// PARAMETERS
//   N_SLOTS  8  number of parking slots (power of 2)
//   NUM_W    3  width of park_number; N_SLOTS == 2**NUM_W
//   CNT_W    4  width of free_count; holds 0..N_SLOTS
// PORTS
//   clk            in   1        single clock, rising edge
//   rst            in   1        asynchronous, active-high reset
//   enter_req      in   1        car at entry gate; sampled only in IDLE
//   grant_ack      in   1        gate has consumed the grant
//   exit_valid     in   1        one-cycle pulse: car leaving slot exit_num
//   exit_num       in   NUM_W    slot being vacated
//   grant_valid    out  1        park_number valid; held until grant_ack
//   park_number    out  NUM_W    allocated slot
//   deny           out  1        one-cycle pulse: request refused because lot is full
//   exit_err       out  1        one-cycle pulse: exit_valid named an already-free slot
//   full           out  1        all slots occupied (combinational from map)
//   park_location  out  N_SLOTS  occupancy map; bit i = 1 means slot i is taken
//   free_count     out  CNT_W    number of zero bits in park_location
// BEHAVIOUR
//   Reset (async, immediate):
//     - State = IDLE; park_location = 0; park_number = 0.
//     - grant_valid, deny, exit_err = 0; free_count = N_SLOTS; full = 0.
//   FSM states: IDLE, SEARCH, GRANT.
//     IDLE:
//       - enter_req & ~full -> SEARCH.
//       - enter_req & full  -> deny = 1 next cycle; stay in IDLE.
//       - otherwise stay in IDLE.
//     SEARCH, one cycle:
//       - Priority-encode the lowest i with park_location[i] == 0, using pre-edge map.
//       - Register park_number = i; set park_location[i] = 1; grant_valid = 1; -> GRANT.
//     GRANT:
//       - Hold park_number and grant_valid stable.
//       - grant_ack -> grant_valid = 0 at that edge; -> IDLE.
//       - grant_ack is ignored in all states except GRANT.
//   Latency:
//     - enter_req sampled at edge E0 -> grant_valid high after edge E1.
//     - Fastest back-to-back grant: 3 cycles (IDLE, SEARCH, GRANT with ack).
//   Exit handling, in any state:
//     - exit_valid & park_location[exit_num] -> clear that bit at the edge.
//     - exit_valid & ~park_location[exit_num] -> map unchanged; exit_err = 1 for one cycle.
//   Simultaneous events:
//     - Exit in the same cycle as SEARCH: the encoder uses the pre-edge map, so the slot
//       being freed is not chosen this cycle.
//     - The clear and the set land in the same edge and never target the same bit.
//   Full and empty:
//     - SEARCH is only entered with at least one free slot; no exit can reduce free slots.
//     - deny is raised only in IDLE.
//     - Empty lot is legal; exit_err covers exits from an empty lot.
//   Arithmetic:
//     - free_count = N_SLOTS - popcount(park_location); combinational; never wraps.
//   Reset mid-operation: GRANT or SEARCH abandoned; any allocated slot is forgotten.
// TESTING
//   1. Reset, then 8 enter/ack handshakes -> park_number 0,1,...,7; then full = 1, free_count = 0.
//   2. Lot full, enter_req -> deny pulses once; grant_valid stays 0; state remains IDLE.
//   3. Full lot, exit_num = 3 -> park_location = 8'hF7; next entry gets park_number 3.
//   4. Empty lot, exit_num = 5 -> exit_err pulse; park_location stays 8'h00.
//   5. Map 8'h01, exit_num = 0 in the SEARCH cycle -> grant 1; park_location = 8'h02.
//   6. Assert rst while in GRANT -> all outputs go to reset values at once; next entry gets 0.

Source files
------------

// File: rtl/entry_parking_lot.sv
// Entry-side slot allocator for the parking lot.
// Keeps the occupancy map and hands out the lowest free slot to an arriving
// car through an IDLE -> SEARCH -> GRANT handshake. Exit notifications free
// slots in any state. An exit that names a slot which is already free is
// flagged with exit_err.
module entry_parking_lot #(
  parameter int N_SLOTS = 8,
  parameter int NUM_W   = 3,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enter_req,
  input  logic               grant_ack,
  input  logic               exit_valid,
  input  logic [NUM_W-1:0]   exit_num,
  output logic               grant_valid,
  output logic [NUM_W-1:0]   park_number,
  output logic               deny,
  output logic               exit_err,
  output logic               full,
  output logic [N_SLOTS-1:0] park_location,
  output logic [CNT_W-1:0]   free_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    GRANT  = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_W-1:0]   free_idx;
  logic               exit_hit;
  logic [N_SLOTS-1:0] clear_mask;
  logic [N_SLOTS-1:0] set_mask;
  logic [N_SLOTS-1:0] next_map;

  // Lowest-numbered zero bit of the map. The scan runs from the top down, so
  // the last assignment made belongs to the lowest free index.
  function automatic logic [NUM_W-1:0] lowest_free(input logic [N_SLOTS-1:0] map);
    logic [NUM_W-1:0] idx;
    idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!map[i]) begin
        idx = NUM_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Number of occupied slots in the map.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_SLOTS-1:0] map);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      cnt = cnt + CNT_W'(map[i]);
    end
    return cnt;
  endfunction

  // Status flags derived directly from the map.
  assign full       = &park_location;
  assign free_count = CNT_W'(N_SLOTS) - popcount(park_location);

  // Next-map computation. The encoder sees the pre-edge map, so a slot that is
  // freed in the SEARCH cycle is never the one chosen. The set and clear masks
  // therefore cannot target the same bit.
  always_comb begin
    free_idx   = lowest_free(park_location);
    exit_hit   = park_location[exit_num];
    clear_mask = '0;
    set_mask   = '0;
    if (exit_valid && exit_hit) begin
      clear_mask[exit_num] = 1'b1;
    end else begin
      clear_mask = '0;
    end
    if (state == SEARCH) begin
      set_mask[free_idx] = 1'b1;
    end else begin
      set_mask = '0;
    end
    next_map = (park_location & ~clear_mask) | set_mask;
  end

  // Allocation FSM with registered grant, deny and exit_err outputs and the
  // occupancy map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      park_location <= '0;
      park_number   <= '0;
      grant_valid   <= 1'b0;
      deny          <= 1'b0;
      exit_err      <= 1'b0;
    end else begin
      park_location <= next_map;
      exit_err      <= exit_valid & ~exit_hit;
      deny          <= 1'b0;
      case (state)
        IDLE: begin
          if (enter_req && full) begin
            deny  <= 1'b1;
            state <= IDLE;
          end else if (enter_req) begin
            state <= SEARCH;
          end else begin
            state <= IDLE;
          end
        end
        SEARCH: begin
          park_number <= free_idx;
          grant_valid <= 1'b1;
          state       <= GRANT;
        end
        GRANT: begin
          if (grant_ack) begin
            grant_valid <= 1'b0;
            state       <= IDLE;
          end else begin
            state       <= GRANT;
          end
        end
        default: begin
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entry_parking_lot.sv
// Directed testbench for entry_parking_lot. Inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_entry_parking_lot;

  logic       clk;
  logic       rst;
  logic       enter_req;
  logic       grant_ack;
  logic       exit_valid;
  logic [2:0] exit_num;
  logic       grant_valid;
  logic [2:0] park_number;
  logic       deny;
  logic       exit_err;
  logic       full;
  logic [7:0] park_location;
  logic [3:0] free_count;

  int checks_total;
  int checks_passed;

  entry_parking_lot #(.N_SLOTS(8), .NUM_W(3), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .enter_req     (enter_req),
    .grant_ack     (grant_ack),
    .exit_valid    (exit_valid),
    .exit_num      (exit_num),
    .grant_valid   (grant_valid),
    .park_number   (park_number),
    .deny          (deny),
    .exit_err      (exit_err),
    .full          (full),
    .park_location (park_location),
    .free_count    (free_count)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total = checks_total + 1;
    if (got === exp) begin
      checks_passed = checks_passed + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full entry handshake. The grant is held for one extra cycle before the ack.
  task automatic do_enter(input string tag, input logic [2:0] exp_num);
    enter_req = 1'b1;
    step();
    enter_req = 1'b0;
    step();
    check({tag, " grant_valid"}, 32'(grant_valid), 32'd1);
    check({tag, " park_number"}, 32'(park_number), 32'(exp_num));
    step();
    check({tag, " held grant"}, 32'(grant_valid), 32'd1);
    check({tag, " held number"}, 32'(park_number), 32'(exp_num));
    grant_ack = 1'b1;
    step();
    grant_ack = 1'b0;
    check({tag, " grant dropped"}, 32'(grant_valid), 32'd0);
  endtask

  task automatic do_exit(input logic [2:0] num);
    exit_valid = 1'b1;
    exit_num   = num;
    step();
    exit_valid = 1'b0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst        = 1'b1;
    enter_req  = 1'b0;
    grant_ack  = 1'b0;
    exit_valid = 1'b0;
    exit_num   = 3'd0;
    step();
    step();
    check("reset map", 32'(park_location), 32'h00);
    check("reset free_count", 32'(free_count), 32'd8);
    check("reset full", 32'(full), 32'd0);
    check("reset grant_valid", 32'(grant_valid), 32'd0);
    check("reset park_number", 32'(park_number), 32'd0);
    check("reset deny", 32'(deny), 32'd0);
    check("reset exit_err", 32'(exit_err), 32'd0);
    rst = 1'b0;
    step();

    // Fill the lot in slot order.
    for (int i = 0; i < 8; i++) begin
      do_enter($sformatf("fill%0d", i), 3'(i));
    end
    check("filled full", 32'(full), 32'd1);
    check("filled free_count", 32'(free_count), 32'd0);
    check("filled map", 32'(park_location), 32'hFF);

    // Request against a full lot.
    enter_req = 1'b1;
    step();
    enter_req = 1'b0;
    check("deny pulse", 32'(deny), 32'd1);
    check("deny no grant", 32'(grant_valid), 32'd0);
    step();
    check("deny cleared", 32'(deny), 32'd0);
    check("deny still no grant", 32'(grant_valid), 32'd0);
    step();
    check("deny stays idle", 32'(grant_valid), 32'd0);

    // Free slot 3 and reuse it.
    do_exit(3'd3);
    check("exit3 map", 32'(park_location), 32'hF7);
    check("exit3 no err", 32'(exit_err), 32'd0);
    check("exit3 free_count", 32'(free_count), 32'd1);
    check("exit3 not full", 32'(full), 32'd0);
    do_enter("reuse3", 3'd3);
    check("reuse3 map", 32'(park_location), 32'hFF);

    // Empty the lot, then exit from an empty lot.
    for (int i = 0; i < 8; i++) begin
      do_exit(3'(i));
    end
    check("emptied map", 32'(park_location), 32'h00);
    check("emptied free_count", 32'(free_count), 32'd8);
    do_exit(3'd5);
    check("empty exit err", 32'(exit_err), 32'd1);
    check("empty exit map", 32'(park_location), 32'h00);
    step();
    check("empty exit err pulse", 32'(exit_err), 32'd0);

    // grant_ack outside GRANT has no effect.
    grant_ack = 1'b1;
    step();
    grant_ack = 1'b0;
    check("stray ack", 32'(grant_valid), 32'd0);

    // Exit in the SEARCH cycle.
    do_enter("pre5", 3'd0);
    check("pre5 map", 32'(park_location), 32'h01);
    enter_req = 1'b1;
    step();
    enter_req  = 1'b0;
    exit_valid = 1'b1;
    exit_num   = 3'd0;
    step();
    exit_valid = 1'b0;
    check("search exit grant", 32'(grant_valid), 32'd1);
    check("search exit number", 32'(park_number), 32'd1);
    check("search exit map", 32'(park_location), 32'h02);
    check("search exit no err", 32'(exit_err), 32'd0);
    grant_ack = 1'b1;
    step();
    grant_ack = 1'b0;
    check("search exit ack", 32'(grant_valid), 32'd0);

    // Reset while in GRANT takes effect without a clock edge.
    enter_req = 1'b1;
    step();
    enter_req = 1'b0;
    step();
    check("pre rst grant", 32'(grant_valid), 32'd1);
    check("pre rst map", 32'(park_location), 32'h03);
    #2;
    rst = 1'b1;
    #1;
    check("async rst grant", 32'(grant_valid), 32'd0);
    check("async rst map", 32'(park_location), 32'h00);
    check("async rst number", 32'(park_number), 32'd0);
    check("async rst free_count", 32'(free_count), 32'd8);
    step();
    rst = 1'b0;
    step();
    do_enter("post rst", 3'd0);
    check("post rst map", 32'(park_location), 32'h01);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
